// File: rtl/lpif_rx_x4_asym2_full_slave_stb_align.sv
// LPIF receive strobe aligner (x4, asym2, full-rate slave).
//
// Extracts 77 data bits and the MARKER bit from each 80-bit PHY word. It also
// locks onto the STROBE bit, which recurs every STB_INTERVAL words.
//
// Ports:
//   clk_rd            receive clock; every flop uses its rising edge
//   rst_rd_n          asynchronous active-low reset
//   rx_phy0[79:0]     PHY word: bit 1 STROBE, bit 77 MARKER, bit 79 unused
//   rx_online         link-up qualifier; low forces IDLE
//   rx_upstream_data  registered extracted data (77 bits)
//   rx_upstream_push  data valid: the word was sampled while LOCKED
//   rx_mrk_userbit    registered MARKER bit, aligned with the data
//   rx_align_done     high while LOCKED
//   rx_stb_err        one-cycle pulse per strobe error in VERIFY/LOCKED
//   rx_stb_err_cnt    saturating strobe error count (kept across rx_online drops)
module lpif_rx_x4_asym2_full_slave_stb_align #(
    parameter int unsigned STB_INTERVAL = 8,
    parameter int unsigned LOCK_CNT     = 4,
    parameter int unsigned UNLOCK_CNT   = 2
) (
    input  logic        clk_rd,
    input  logic        rst_rd_n,
    input  logic [79:0] rx_phy0,
    input  logic        rx_online,
    output logic [76:0] rx_upstream_data,
    output logic        rx_upstream_push,
    output logic        rx_mrk_userbit,
    output logic        rx_align_done,
    output logic        rx_stb_err,
    output logic [7:0]  rx_stb_err_cnt
);

    localparam int unsigned PhW       = (STB_INTERVAL > 2) ? $clog2(STB_INTERVAL) : 1;
    localparam logic [PhW-1:0] PhLast = PhW'(STB_INTERVAL - 1);
    localparam logic [3:0] LockCnt    = 4'(LOCK_CNT);
    localparam logic [3:0] UnlockCnt  = 4'(UNLOCK_CNT);

    typedef enum logic [1:0] {StIdle, StHunt, StVerify, StLocked} state_e;

    state_e           state_q, state_d;
    logic [PhW-1:0]   phase_q, phase_d, phase_inc;
    logic [3:0]       good_q, good_d;
    logic [3:0]       bad_q, bad_d;
    logic             err_d;
    logic [7:0]       err_cnt_d;
    logic [76:0]      data_d;
    logic             strobe, exp_stb, stb_mismatch;
    logic             unused_bit79;

    assign unused_bit79 = rx_phy0[79];

    assign strobe       = rx_phy0[1];
    assign exp_stb      = (phase_q == '0);
    assign stb_mismatch = (strobe != exp_stb);
    assign phase_inc    = (phase_q == PhLast) ? '0 : phase_q + 1'b1;

    // STROBE (bit 1), MARKER (bit 77) and bit 79 are squeezed out of the data.
    assign data_d = {rx_phy0[78], rx_phy0[76:2], rx_phy0[0]};

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        good_d  = good_q;
        bad_d   = bad_q;
        err_d   = 1'b0;
        if (!rx_online) begin
            state_d = StIdle;
            phase_d = '0;
            good_d  = '0;
            bad_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StHunt;
                StHunt: begin
                    if (strobe) begin
                        // This word is phase 0, so the next word is phase 1.
                        phase_d = PhW'(1);
                        good_d  = 4'd1;
                        bad_d   = '0;
                        state_d = (LockCnt == 4'd1) ? StLocked : StVerify;
                    end
                end
                StVerify: begin
                    phase_d = phase_inc;
                    if (stb_mismatch) begin
                        err_d   = 1'b1;
                        good_d  = '0;
                        state_d = StHunt;
                    end else if (exp_stb) begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == LockCnt) begin
                            bad_d   = '0;
                            state_d = StLocked;
                        end
                    end
                end
                StLocked: begin
                    phase_d = phase_inc;
                    if (stb_mismatch) begin
                        err_d = 1'b1;
                        if (bad_q + 4'd1 == UnlockCnt) begin
                            bad_d   = '0;
                            good_d  = '0;
                            state_d = StHunt;
                        end else begin
                            bad_d = bad_q + 4'd1;
                        end
                    end else if (exp_stb) begin
                        bad_d = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign err_cnt_d = (err_d && (rx_stb_err_cnt != 8'hFF)) ? rx_stb_err_cnt + 8'd1
                                                             : rx_stb_err_cnt;

    always_ff @(posedge clk_rd or negedge rst_rd_n) begin
        if (!rst_rd_n) begin
            state_q          <= StIdle;
            phase_q          <= '0;
            good_q           <= '0;
            bad_q            <= '0;
            rx_upstream_data <= '0;
            rx_mrk_userbit   <= 1'b0;
            rx_upstream_push <= 1'b0;
            rx_stb_err       <= 1'b0;
            rx_stb_err_cnt   <= '0;
        end else begin
            state_q          <= state_d;
            phase_q          <= phase_d;
            good_q           <= good_d;
            bad_q            <= bad_d;
            rx_upstream_data <= data_d;
            rx_mrk_userbit   <= rx_phy0[77];
            // Push reflects the state the word was sampled in, so the locking word is dropped.
            rx_upstream_push <= (state_q == StLocked);
            rx_stb_err       <= err_d;
            rx_stb_err_cnt   <= err_cnt_d;
        end
    end

    assign rx_align_done = (state_q == StLocked);

endmodule

// File: tb/tb_lpif_rx_x4_asym2_full_slave_stb_align.sv
// Scoreboard bench for the LPIF receive strobe aligner.
// The stimulus side runs a position-based reference model and queues the expected
// response for each word. A monitor pops and compares those responses after every
// clock edge. A second instance with STB_INTERVAL=2 exercises counter saturation.
module tb_lpif_rx_x4_asym2_full_slave_stb_align;

    localparam int N      = 8;
    localparam int LOCK   = 4;
    localparam int UNLOCK = 2;
    localparam int MIdle = 0, MHunt = 1, MVerify = 2, MLocked = 3;

    logic        clk = 1'b0;
    logic        rst_rd_n;
    logic [79:0] rx_phy0, rx_phy0_2;
    logic        rx_online, rx_online_2;
    logic [76:0] data, data_2;
    logic        push, push_2, mrk, mrk_2, done, done_2, err, err_2;
    logic [7:0]  cnt, cnt_2;

    always #5 clk = ~clk;

    lpif_rx_x4_asym2_full_slave_stb_align #(
        .STB_INTERVAL(N), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK)
    ) u_dut (
        .clk_rd(clk), .rst_rd_n(rst_rd_n), .rx_phy0(rx_phy0), .rx_online(rx_online),
        .rx_upstream_data(data), .rx_upstream_push(push), .rx_mrk_userbit(mrk),
        .rx_align_done(done), .rx_stb_err(err), .rx_stb_err_cnt(cnt)
    );

    lpif_rx_x4_asym2_full_slave_stb_align #(
        .STB_INTERVAL(2), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK)
    ) u_dut_sat (
        .clk_rd(clk), .rst_rd_n(rst_rd_n), .rx_phy0(rx_phy0_2), .rx_online(rx_online_2),
        .rx_upstream_data(data_2), .rx_upstream_push(push_2), .rx_mrk_userbit(mrk_2),
        .rx_align_done(done_2), .rx_stb_err(err_2), .rx_stb_err_cnt(cnt_2)
    );

    typedef struct {
        int mode;
        int anchor;
        int t;
        int good;
        int bad;
        int errs;
        bit push;
        bit err;
    } mdl_t;

    typedef struct {
        logic [76:0] data;
        logic        mrk;
        logic        push;
        logic        err;
        logic [7:0]  cnt;
        logic        done;
    } exp_t;

    mdl_t        m, m2;
    exp_t        st_q[$];
    logic [76:0] data_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          ph = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Strobe expected where the distance from the hunt anchor is a multiple of n.
    function automatic mdl_t step(input mdl_t m_in, input int n, input bit on, input bit stb);
        mdl_t m_o;
        bit   expect_stb;
        m_o      = m_in;
        m_o.push = (m_o.mode == MLocked);
        m_o.err  = 1'b0;
        m_o.t++;
        if (!on) begin
            m_o.mode = MIdle;
            m_o.good = 0;
            m_o.bad  = 0;
            return m_o;
        end
        case (m_o.mode)
            MIdle: m_o.mode = MHunt;
            MHunt: begin
                if (stb) begin
                    m_o.anchor = m_o.t;
                    m_o.good   = 1;
                    m_o.mode   = (LOCK == 1) ? MLocked : MVerify;
                end
            end
            default: begin
                expect_stb = ((m_o.t - m_o.anchor) % n) == 0;
                if (stb != expect_stb) begin
                    m_o.err  = 1'b1;
                    m_o.errs = (m_o.errs < 255) ? m_o.errs + 1 : 255;
                    if (m_o.mode == MVerify) begin
                        m_o.mode = MHunt;
                    end else begin
                        m_o.bad++;
                        if (m_o.bad >= UNLOCK) begin
                            m_o.mode = MHunt;
                            m_o.bad  = 0;
                        end
                    end
                end else if (stb) begin
                    if (m_o.mode == MVerify) begin
                        m_o.good++;
                        if (m_o.good >= LOCK) begin
                            m_o.mode = MLocked;
                            m_o.bad  = 0;
                        end
                    end else begin
                        m_o.bad = 0;
                    end
                end
            end
        endcase
        return m_o;
    endfunction

    function automatic logic [76:0] extract(input logic [79:0] w);
        logic [76:0] d;
        d[0] = w[0];
        for (int k = 1; k <= 75; k++) d[k] = w[k+1];
        d[76] = w[78];
        return d;
    endfunction

    task automatic drive_raw(input bit on, input logic [79:0] w);
        exp_t e;
        @(negedge clk);
        rx_online = on;
        rx_phy0   = w;
        m         = step(m, N, on, w[1]);
        e.data    = extract(w);
        e.mrk     = w[77];
        e.push    = m.push;
        e.err     = m.err;
        e.cnt     = 8'(m.errs);
        e.done    = (m.mode == MLocked);
        st_q.push_back(e);
        if (e.push) data_q.push_back(e.data);
    endtask

    task automatic drive(input bit on, input bit stb);
        logic [79:0] w;
        w    = {16'($urandom), $urandom, $urandom};
        w[1] = stb;
        drive_raw(on, w);
    endtask

    task automatic good_words(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, ph == 0);
            ph = (ph + 1) % N;
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expected response per driven word, plus pushed-data ordering.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (st_q.size() > 0) begin
            e = st_q.pop_front();
            check("data", {3'b0, data}, {3'b0, e.data});
            check("marker", {79'b0, mrk}, {79'b0, e.mrk});
            check("push", {79'b0, push}, {79'b0, e.push});
            check("stb_err", {79'b0, err}, {79'b0, e.err});
            check("err_cnt", {72'b0, cnt}, {72'b0, e.cnt});
            check("align_done", {79'b0, done}, {79'b0, e.done});
        end
        if (push && rst_rd_n) begin
            if (data_q.size() == 0) begin
                miscompares++;
                vectors++;
                $display("FAIL push_data: got push with data %h, expected no push", data);
            end else begin
                check("push_data", {3'b0, data}, {3'b0, data_q.pop_front()});
            end
        end
    end

    initial begin
        logic [79:0] w;
        logic [76:0] top_bit;
        int          waited;
        top_bit     = 77'b1 << 76;
        m           = '{default: 0};
        m2          = '{default: 0};
        rst_rd_n    = 1'b0;
        rx_online   = 1'b0;
        rx_online_2 = 1'b0;
        rx_phy0     = '0;
        rx_phy0_2   = '0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_push", {79'b0, push}, 80'd0);
        check("reset_done", {79'b0, done}, 80'd0);
        check("reset_cnt", {72'b0, cnt}, 80'd0);
        @(negedge clk);
        rst_rd_n = 1'b1;

        // Clean lock: strobe every 8th word, lock on the 4th strobe.
        drive(1'b1, 1'b0);
        for (int i = 0; i < 25; i++) drive(1'b1, (i % N) == 0);
        settle();
        check("lock_done", {79'b0, done}, 80'd1);
        check("lock_word_not_pushed", {79'b0, push}, 80'd0);
        drive(1'b1, 1'b0);
        settle();
        check("push_after_lock", {79'b0, push}, 80'd1);
        check("clean_cnt", {72'b0, cnt}, 80'd0);
        ph = 2;

        // Extraction of bit 78 into data[76], MARKER into the user bit.
        while (ph != 0) good_words(1);
        w = '0;
        w[1] = 1'b1;
        w[77] = 1'b1;
        w[78] = 1'b1;
        drive_raw(1'b1, w);
        ph = 1;
        settle();
        check("extract_data", {3'b0, data}, {3'b0, top_bit});
        check("extract_marker", {79'b0, mrk}, 80'd1);

        // Single missed strobe keeps lock; a good strobe clears the bad count.
        while (ph != 0) good_words(1);
        drive(1'b1, 1'b0);
        ph = 1;
        settle();
        check("miss_err", {79'b0, err}, 80'd1);
        check("miss_cnt", {72'b0, cnt}, 80'd1);
        check("miss_locked", {79'b0, done}, 80'd1);
        good_words(8);
        while (ph != 0) good_words(1);
        drive(1'b1, 1'b0);
        ph = 1;
        settle();
        check("second_miss_locked", {79'b0, done}, 80'd1);
        good_words(8);

        // Strobe shifted by 3 words: second error unlocks, then relock.
        while (ph != 0) good_words(1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        settle();
        check("unlock_done", {79'b0, done}, 80'd0);
        check("unlock_err", {79'b0, err}, 80'd1);
        drive(1'b1, 1'b0);
        settle();
        check("unlock_push_stops", {79'b0, push}, 80'd0);
        ph = 2;
        good_words(31);
        settle();
        check("relock_done", {79'b0, done}, 80'd1);

        // Random noise: occasional strobe flips and link drops.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 49) != 0, (ph == 0) ^ ($urandom_range(0, 11) == 0));
            ph = (ph + 1) % N;
        end

        // Online drop while locked: IDLE next edge, count held.
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        ph = 0;
        good_words(33);
        settle();
        check("pre_drop_done", {79'b0, done}, 80'd1);
        drive(1'b0, 1'b0);
        settle();
        check("drop_done", {79'b0, done}, 80'd0);
        check("drop_cnt_held", {72'b0, cnt}, {72'b0, 8'(m.errs)});

        // Asynchronous reset mid-VERIFY.
        drive(1'b1, 1'b0);
        ph = 0;
        good_words(3);
        settle();
        rx_online = 1'b0;
        #1;
        rst_rd_n = 1'b0;
        #1;
        check("async_rst_data", {3'b0, data}, 80'd0);
        check("async_rst_marker", {79'b0, mrk}, 80'd0);
        check("async_rst_push", {79'b0, push}, 80'd0);
        check("async_rst_done", {79'b0, done}, 80'd0);
        check("async_rst_err", {79'b0, err}, 80'd0);
        check("async_rst_cnt", {72'b0, cnt}, 80'd0);
        m  = '{default: 0};
        m2 = '{default: 0};
        @(posedge clk);
        @(negedge clk);
        rst_rd_n = 1'b1;
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);

        // Saturation: STB_INTERVAL=2 with STROBE stuck high.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rx_online_2 = 1'b1;
            w = {16'($urandom), $urandom, $urandom};
            w[1] = 1'b1;
            rx_phy0_2 = w;
            m2 = step(m2, 2, 1'b1, 1'b1);
            if (i == 99) begin
                settle();
                check("sat_partial_cnt", {72'b0, cnt_2}, {72'b0, 8'(m2.errs)});
            end
        end
        settle();
        check("sat_cnt_model", {72'b0, cnt_2}, {72'b0, 8'(m2.errs)});
        check("sat_cnt_255", {72'b0, cnt_2}, 80'd255);

        waited = 0;
        while (st_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #3;
        if (st_q.size() != 0 || data_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d responses and %0d pushes still pending",
                     st_q.size(), data_q.size());
        end
        vectors++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
